instruction_sequencer: RTL and testbench

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/instruction_sequencer.sv | 101 ++++++++++
 tb/tb_instruction_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Four-stage instruction sequencer: steps fetch / read vr / read vrw / write vw-pc
// on memory acknowledges, maintains the program counter and faults on a stalled access.
module instruction_sequencer #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ack,
  output logic [1:0]      stage,
  output logic [0:3]      stage_done,
  output logic [PC_W-1:0] pc,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_load_value,
  output logic            busy,
  output logic            fault
);

  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_FAULT
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        stage_q, stage_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [0:3]        done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      pc_q    <= '0;
      wait_q  <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      pc_q    <= pc_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    pc_d    = pc_q;
    wait_d  = wait_q;
    done_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_ACTIVE;
          stage_d = '0;
          wait_d  = '0;
        end
      end
      S_ACTIVE: begin
        if (mem_ack) begin
          // An ack on the edge the counter would expire still completes the stage.
          done_d[stage_q] = 1'b1;
          wait_d          = '0;
          if (stage_q == 2'd3) begin
            pc_d    = pc_load ? pc_load_value : pc_q + 1'b1;
            stage_d = '0;
            state_d = run ? S_ACTIVE : S_IDLE;
          end else begin
            stage_d = stage_q + 2'd1;
          end
        end else begin
          wait_d = wait_q + 1'b1;
          if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_req    = (state_q == S_ACTIVE);
  assign busy       = (state_q == S_ACTIVE);
  assign mem_we     = (state_q == S_ACTIVE) && (stage_q == 2'd3);
  assign fault      = (state_q == S_FAULT);
  assign stage      = stage_q;
  assign pc         = pc_q;
  assign stage_done = done_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer: pipeline cadence, pc load/wrap,
// timeout boundary, run drop, async reset and ignored acks.
module tb_instruction_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic       mem_req;
  logic       mem_we;
  logic       mem_ack;
  logic [1:0] stage;
  logic [0:3] stage_done;
  logic [7:0] pc;
  logic       pc_load;
  logic [7:0] pc_load_value;
  logic       busy;
  logic       fault;

  int unsigned n_checks;
  int unsigned n_fail;

  instruction_sequencer #(.PC_W(8), .TIMEOUT(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_ack      (mem_ack),
    .stage        (stage),
    .stage_done   (stage_done),
    .pc           (pc),
    .pc_load      (pc_load),
    .pc_load_value(pc_load_value),
    .busy         (busy),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stage-done pattern as seen on the [0:3] port: stage n lights bit n (leftmost = stage 0).
  function automatic logic [3:0] oh(input int s);
    return 4'b1000 >> s;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    run           = 1'b0;
    mem_ack       = 1'b0;
    pc_load       = 1'b0;
    pc_load_value = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_stage", stage, 0);
    check("rst_pc", pc, 0);
    check("rst_done", stage_done, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_mem_req", mem_req, 0);

    // Back-to-back instructions with ack held high
    run = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    for (int i = 0; i <= 12; i++) begin
      check("seq_stage", stage, i % 4);
      check("seq_done", stage_done, (i == 0) ? 0 : oh((i - 1) % 4));
      check("seq_pc", pc, i / 4);
      check("seq_mem_req", mem_req, 1);
      check("seq_mem_we", mem_we, (i % 4) == 3);
      @(negedge clk);
    end

    // pc load, wrap and ignored load outside stage 3
    do_reset();
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("ld_stage3", stage, 3);
    pc_load = 1'b1;
    pc_load_value = 8'hFF;
    @(negedge clk);
    check("ld_pc_ff", pc, 8'hFF);
    pc_load = 1'b0;
    repeat (4) @(negedge clk);
    check("wrap_pc", pc, 8'h00);
    check("wrap_stage", stage, 0);
    pc_load = 1'b1;
    pc_load_value = 8'h77;
    repeat (2) @(negedge clk);
    check("ign_stage2", stage, 2);
    check("ign_pc_s1", pc, 8'h00);
    @(negedge clk);
    check("ign_pc_s2", pc, 8'h00);
    pc_load_value = 8'h42;
    @(negedge clk);
    check("ld_pc_42", pc, 8'h42);
    check("ld_stage0", stage, 0);
    pc_load = 1'b0;

    // Timeout boundary: 14 stalled cycles survive, 15 fault
    do_reset();
    run = 1'b1;
    mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("to_stage2", stage, 2);
    mem_ack = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check("to14_fault", fault, 0);
      check("to14_stage", stage, 2);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    check("to14_adv_stage", stage, 3);
    check("to14_adv_fault", fault, 0);
    repeat (3) @(negedge clk);
    check("to15_stage2", stage, 2);
    check("to15_pc", pc, 1);
    mem_ack = 1'b0;
    repeat (14) @(negedge clk);
    check("to15_pre_fault", fault, 0);
    @(negedge clk);
    check("to15_fault", fault, 1);
    check("to15_mem_req", mem_req, 0);
    check("to15_busy", busy, 0);
    check("to15_mem_we", mem_we, 0);
    check("to15_stage", stage, 2);
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flt_fault", fault, 1);
      check("flt_stage", stage, 2);
      check("flt_pc", pc, 1);
      check("flt_done", stage_done, 0);
      check("flt_mem_req", mem_req, 0);
    end

    // run dropped mid-instruction completes it, then idles
    do_reset();
    run = 1'b1;
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    check("rd_stage1", stage, 1);
    run = 1'b0;
    @(negedge clk);
    check("rd_stage2", stage, 2);
    @(negedge clk);
    check("rd_stage3", stage, 3);
    check("rd_mem_we", mem_we, 1);
    @(negedge clk);
    check("rd_idle_req", mem_req, 0);
    check("rd_idle_busy", busy, 0);
    check("rd_pc", pc, 1);
    check("rd_done", stage_done, oh(3));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ack_req", mem_req, 0);
      check("idle_ack_pc", pc, 1);
      check("idle_ack_done", stage_done, 0);
    end

    // Asynchronous reset during stalled stage 3
    run = 1'b1;
    @(negedge clk);
    check("ar_stage0", stage, 0);
    check("ar_pc1", pc, 1);
    repeat (3) @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    check("ar_stage3", stage, 3);
    check("ar_done_idle", stage_done, 0);
    #2;
    reset = 1'b1;
    #1;
    check("ar_mem_req", mem_req, 0);
    check("ar_mem_we", mem_we, 0);
    check("ar_busy", busy, 0);
    check("ar_fault", fault, 0);
    check("ar_stage", stage, 0);
    check("ar_pc", pc, 0);
    check("ar_done", stage_done, 0);
    @(negedge clk);
    reset = 1'b0;
    check("ar_post_pc", pc, 0);
    mem_ack = 1'b1;
    @(negedge clk);
    check("ar_restart_stage", stage, 0);
    check("ar_restart_pc", pc, 0);
    check("ar_restart_req", mem_req, 1);
    check("ar_restart_done0", stage_done, 0);
    @(negedge clk);
    check("ar_restart_done", stage_done, oh(0));
    check("ar_restart_stage1", stage, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
